sp_if_seq_ddr_mch: RTL and testbench

//  Parametrised multi-channel DDR/signal-processing sequencer for the sonar sp_if path.
//  Per frame: DDR read for each enabled input channel, signal-processing start, DDR write-back, completion pulses.

---
 rtl/sp_if_seq_ddr_mch_if.sv | 69 ++++++
 rtl/sp_if_seq_ddr_mch.sv | 219 +++++++++++++++++++++
 tb/tb_sp_if_seq_ddr_mch.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_if_seq_ddr_mch_if.sv
// Bus bundle between the sp_if sequencer and its environment (control/DDR
// arbiter on one side, sp_if RAM blocks on the other).
//   master : environment side; drives the i_* signals, observes the o_* ones
//   slave  : sequencer side;   observes the i_* signals, drives the o_* ones
// Signals:
//   i_frame_max, i_frame_offset, i_rd_addr, i_rd_size, i_wr_addr, i_wr_size,
//   i_ch_en, i_tout_max                          frame configuration
//   i_ctrl_startp, i_skip_tx, i_sync_on          frame start control
//   i_ddr_endp, i_rxfifo_rd_last, i_sp_end       completion events
//   o_frame_time, o_ram_offset_addr              frame counter / RAM offsets
//   o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size, o_ddr_start,
//   o_ddr_rd_startp, o_ddr_wr_startp             DDR request
//   o_sp_start, o_ddr_endp, o_ctrl_endp          phase pulses
//   o_busy, o_tout_err, o_ovr_err                status
interface sp_if_seq_ddr_mch_if #(
  parameter int NUM_CH = 2,
  parameter int OFS_W  = 32,
  parameter int DDR_AW = 27,
  parameter int TOUT_W = 24
);
  logic [3:0]               i_frame_max;
  logic [NUM_CH*OFS_W-1:0]  i_frame_offset;
  logic [NUM_CH*DDR_AW-1:0] i_rd_addr;
  logic [31:0]              i_rd_size;
  logic [DDR_AW-1:0]        i_wr_addr;
  logic [31:0]              i_wr_size;
  logic [NUM_CH-1:0]        i_ch_en;
  logic [TOUT_W-1:0]        i_tout_max;
  logic                     i_ctrl_startp;
  logic                     i_skip_tx;
  logic                     i_sync_on;
  logic                     i_ddr_endp;
  logic                     i_rxfifo_rd_last;
  logic                     i_sp_end;

  logic [3:0]               o_frame_time;
  logic [NUM_CH*OFS_W-1:0]  o_ram_offset_addr;
  logic                     o_ddr_wxr;
  logic [3:0]               o_ddr_area;
  logic [DDR_AW-1:0]        o_ddr_addr;
  logic [31:0]              o_ddr_size;
  logic                     o_ddr_start;
  logic                     o_ddr_rd_startp;
  logic                     o_ddr_wr_startp;
  logic                     o_sp_start;
  logic                     o_ddr_endp;
  logic                     o_ctrl_endp;
  logic                     o_busy;
  logic                     o_tout_err;
  logic                     o_ovr_err;

  modport master (
    output i_frame_max, i_frame_offset, i_rd_addr, i_rd_size, i_wr_addr, i_wr_size,
           i_ch_en, i_tout_max, i_ctrl_startp, i_skip_tx, i_sync_on, i_ddr_endp,
           i_rxfifo_rd_last, i_sp_end,
    input  o_frame_time, o_ram_offset_addr, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size,
           o_ddr_start, o_ddr_rd_startp, o_ddr_wr_startp, o_sp_start, o_ddr_endp,
           o_ctrl_endp, o_busy, o_tout_err, o_ovr_err
  );

  modport slave (
    input  i_frame_max, i_frame_offset, i_rd_addr, i_rd_size, i_wr_addr, i_wr_size,
           i_ch_en, i_tout_max, i_ctrl_startp, i_skip_tx, i_sync_on, i_ddr_endp,
           i_rxfifo_rd_last, i_sp_end,
    output o_frame_time, o_ram_offset_addr, o_ddr_wxr, o_ddr_area, o_ddr_addr, o_ddr_size,
           o_ddr_start, o_ddr_rd_startp, o_ddr_wr_startp, o_sp_start, o_ddr_endp,
           o_ctrl_endp, o_busy, o_tout_err, o_ovr_err
  );
endinterface

// File: rtl/sp_if_seq_ddr_mch.sv
// Multi-channel DDR / signal-processing frame sequencer for the sonar sp_if
// path. Per frame: one DDR read per enabled input channel (area = channel),
// a signal-processing start, one DDR write-back (area = NUM_CH), then the
// completion pulses. Includes a per-wait-state watchdog and overrun flag.
// Ports:
//   i_clk156m : system clock
//   i_rst_n   : synchronous reset, active-low
//   bus       : sp_if_seq_ddr_mch_if slave modport (configuration, events,
//               DDR request, pulses and status)
module sp_if_seq_ddr_mch #(
  parameter int NUM_CH = 2,
  parameter int OFS_W  = 32,
  parameter int DDR_AW = 27,
  parameter int TOUT_W = 24
) (
  input  logic               i_clk156m,
  input  logic               i_rst_n,
  sp_if_seq_ddr_mch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, SP_REQ, SP_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  localparam int              CH_W  = 5;
  localparam logic [CH_W-1:0] NO_CH = CH_W'(NUM_CH);

  // Lowest enabled channel at or above 'from'; NO_CH when there is none.
  // Scanning downward lets the lowest match overwrite higher ones.
  function automatic logic [CH_W-1:0] lowest_from(input logic [NUM_CH-1:0] en,
                                                  input int from);
    logic [CH_W-1:0] r;
    r = NO_CH;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (c >= from && en[c]) r = CH_W'(c);
    return r;
  endfunction

  state_t            state;
  logic [3:0]        ch;
  logic [NUM_CH-1:0] ch_en_q;
  logic              sync_q;
  logic              got_endp;
  logic              got_last;
  logic [TOUT_W-1:0] wd_cnt;

  logic [CH_W-1:0]   rd_sel;
  logic [DDR_AW-1:0] rd_addr_sel;
  logic              in_wait;
  logic              wd_fire;
  logic              rd_both;

  // From IDLE the first channel comes from the live mask; afterwards from
  // the mask captured at start, searching above the channel just finished.
  assign rd_sel = (state == IDLE) ? lowest_from(bus.i_ch_en, 0)
                                  : lowest_from(ch_en_q, int'(ch) + 1);

  always_comb begin
    rd_addr_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_sel == CH_W'(c)) rd_addr_sel = bus.i_rd_addr[c*DDR_AW +: DDR_AW];
  end

  assign in_wait = (state == RD_WAIT) || (state == SP_WAIT) || (state == WR_WAIT);
  // wd_cnt holds the cycles already spent in the current wait state, so the
  // limit is hit on the i_tout_max-th cycle of waiting.
  assign wd_fire = in_wait && (bus.i_tout_max != '0) &&
                   (wd_cnt == bus.i_tout_max - TOUT_W'(1));
  // Read completion needs both the DDR end and the FIFO drain, in any order.
  assign rd_both = (got_endp | bus.i_ddr_endp) & (got_last | bus.i_rxfifo_rd_last);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk156m) begin
    // NOTE: reset is synchronous -- sampled only at the clock edge.
    if (!i_rst_n) begin
      state                 <= IDLE;
      ch                    <= '0;
      ch_en_q               <= '0;
      sync_q                <= 1'b0;
      got_endp              <= 1'b0;
      got_last              <= 1'b0;
      wd_cnt                <= '0;
      bus.o_frame_time      <= '0;
      bus.o_ram_offset_addr <= '0;
      bus.o_ddr_wxr         <= 1'b0;
      bus.o_ddr_area        <= '0;
      bus.o_ddr_addr        <= '0;
      bus.o_ddr_size        <= '0;
      bus.o_ddr_start       <= 1'b0;
      bus.o_ddr_rd_startp   <= 1'b0;
      bus.o_ddr_wr_startp   <= 1'b0;
      bus.o_sp_start        <= 1'b0;
      bus.o_ddr_endp        <= 1'b0;
      bus.o_ctrl_endp       <= 1'b0;
      bus.o_busy            <= 1'b0;
      bus.o_tout_err        <= 1'b0;
      bus.o_ovr_err         <= 1'b0;
    end else begin
      bus.o_ddr_start     <= 1'b0;
      bus.o_ddr_rd_startp <= 1'b0;
      bus.o_ddr_wr_startp <= 1'b0;
      bus.o_sp_start      <= 1'b0;
      bus.o_ddr_endp      <= 1'b0;
      bus.o_ctrl_endp     <= 1'b0;
      bus.o_ovr_err       <= bus.i_ctrl_startp && (state != IDLE);
      // Every wait state is entered from a non-wait state, so this alone
      // restarts the watchdog on each state change.
      wd_cnt              <= in_wait ? wd_cnt + TOUT_W'(1) : '0;

      case (state)
        IDLE: begin
          if (bus.i_ctrl_startp) begin
            bus.o_busy     <= 1'b1;
            bus.o_tout_err <= 1'b0;
            sync_q         <= bus.i_sync_on;
            ch_en_q        <= bus.i_ch_en;
            got_endp       <= 1'b0;
            got_last       <= 1'b0;
            if (bus.i_skip_tx || bus.o_frame_time == bus.i_frame_max) begin
              bus.o_frame_time      <= '0;
              bus.o_ram_offset_addr <= '0;
            end else begin
              bus.o_frame_time <= bus.o_frame_time + 4'd1;
              for (int c = 0; c < NUM_CH; c++)
                bus.o_ram_offset_addr[c*OFS_W +: OFS_W] <=
                  bus.o_ram_offset_addr[c*OFS_W +: OFS_W] + bus.i_frame_offset[c*OFS_W +: OFS_W];
            end
            if (rd_sel != NO_CH) begin
              state               <= RD_REQ;
              ch                  <= rd_sel[3:0];
              bus.o_ddr_start     <= 1'b1;
              bus.o_ddr_rd_startp <= 1'b1;
              bus.o_ddr_wxr       <= 1'b0;
              bus.o_ddr_area      <= rd_sel[3:0];
              bus.o_ddr_addr      <= rd_addr_sel;
              bus.o_ddr_size      <= bus.i_rd_size;
            end else begin
              state <= SP_REQ;
            end
          end
        end

        RD_REQ: state <= RD_WAIT;

        RD_WAIT: begin
          if (rd_both) begin
            got_endp <= 1'b0;
            got_last <= 1'b0;
            if (rd_sel != NO_CH) begin
              state               <= RD_REQ;
              ch                  <= rd_sel[3:0];
              bus.o_ddr_start     <= 1'b1;
              bus.o_ddr_rd_startp <= 1'b1;
              bus.o_ddr_wxr       <= 1'b0;
              bus.o_ddr_area      <= rd_sel[3:0];
              bus.o_ddr_addr      <= rd_addr_sel;
              bus.o_ddr_size      <= bus.i_rd_size;
            end else begin
              state <= SP_REQ;
            end
          end else if (wd_fire) begin
            state          <= IDLE;
            bus.o_busy     <= 1'b0;
            bus.o_tout_err <= 1'b1;
            got_endp       <= 1'b0;
            got_last       <= 1'b0;
          end else begin
            got_endp <= got_endp | bus.i_ddr_endp;
            got_last <= got_last | bus.i_rxfifo_rd_last;
          end
        end

        SP_REQ: begin
          state          <= SP_WAIT;
          bus.o_sp_start <= 1'b1;
        end

        SP_WAIT: begin
          if (bus.i_sp_end) begin
            state               <= WR_REQ;
            bus.o_ddr_start     <= 1'b1;
            bus.o_ddr_wr_startp <= 1'b1;
            bus.o_ddr_wxr       <= 1'b1;
            bus.o_ddr_area      <= 4'(NUM_CH);
            bus.o_ddr_addr      <= bus.i_wr_addr;
            bus.o_ddr_size      <= bus.i_wr_size;
          end else if (wd_fire) begin
            state          <= IDLE;
            bus.o_busy     <= 1'b0;
            bus.o_tout_err <= 1'b1;
          end
        end

        WR_REQ: state <= WR_WAIT;

        WR_WAIT: begin
          if (bus.i_ddr_endp) begin
            state          <= DONE;
            bus.o_ddr_endp <= 1'b1;
          end else if (wd_fire) begin
            state          <= IDLE;
            bus.o_busy     <= 1'b0;
            bus.o_tout_err <= 1'b1;
          end
        end

        DONE: begin
          state           <= IDLE;
          bus.o_busy      <= 1'b0;
          bus.o_ctrl_endp <= !sync_q;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_if_seq_ddr_mch.sv
`timescale 1ns/1ps
// Bench for sp_if_seq_ddr_mch with NUM_CH=2. Each frame's expected pulse
// schedule is derived from the sequencing rules (request/latency per phase)
// and compared against the DUT every cycle; literal checks pin key timings.
module tb_sp_if_seq_ddr_mch;
  localparam int NUM_CH = 2, OFS_W = 32, DDR_AW = 27, TOUT_W = 24;
  localparam logic [DDR_AW-1:0] RD_A0 = 27'h010_0000;
  localparam logic [DDR_AW-1:0] RD_A1 = 27'h020_0000;
  localparam logic [DDR_AW-1:0] WR_A  = 27'h030_0000;
  localparam logic [31:0] RD_SZ = 32'h1000, WR_SZ = 32'h2000;
  localparam logic [31:0] OFS0 = 32'h100, OFS1 = 32'h200;
  localparam logic [3:0]  FRAME_MAX = 4'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  sp_if_seq_ddr_mch_if #(.NUM_CH(NUM_CH), .OFS_W(OFS_W), .DDR_AW(DDR_AW), .TOUT_W(TOUT_W)) bus ();
  sp_if_seq_ddr_mch #(.NUM_CH(NUM_CH), .OFS_W(OFS_W), .DDR_AW(DDR_AW), .TOUT_W(TOUT_W)) dut (
    .i_clk156m (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct {
    bit              wxr;
    logic [3:0]      area;
    logic [DDR_AW-1:0] addr;
    logic [31:0]     size;
  } req_t;

  req_t e_req[int];                       // expected DDR request per cycle
  bit   e_sp[int], e_dend[int], e_cend[int], e_busy[int], e_ovr[int], e_tout[int];
  bit   d_start[int], d_endp[int], d_last[int], d_sp[int];   // input schedule
  logic [3:0]  m_ft;
  logic [31:0] m_ofs[NUM_CH];
  bit   m_tout;
  req_t m_req;
  int   g_t, g_l0, g_s, g_w;

  // ---------------- observation for literal pins ----------------
  int mon_first_req, mon_rd1_cyc, mon_sp_cyc, mon_tout_cyc, mon_cend_cyc;
  int n_rd, n_cend, n_dend, n_ovr;

  task automatic mon_clear();
    mon_first_req = -1; mon_rd1_cyc = -1; mon_sp_cyc = -1; mon_tout_cyc = -1;
    mon_cend_cyc = -1; n_rd = 0; n_cend = 0; n_dend = 0; n_ovr = 0;
  endtask

  always @(negedge clk) begin
    if (bus.o_ddr_start && mon_first_req < 0) mon_first_req = cyc;
    if (bus.o_ddr_rd_startp) n_rd++;
    if (bus.o_ddr_rd_startp && bus.o_ddr_area == 4'd1) mon_rd1_cyc = cyc;
    if (bus.o_sp_start) mon_sp_cyc = cyc;
    if (bus.o_tout_err && mon_tout_cyc < 0) mon_tout_cyc = cyc;
    if (bus.o_ctrl_endp) begin n_cend++; mon_cend_cyc = cyc; end
    if (bus.o_ddr_endp) n_dend++;
    if (bus.o_ovr_err) n_ovr++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit rq;
    if (chk_en) begin
      rq = e_req.exists(cyc);
      if (rq) m_req = e_req[cyc];
      if (e_tout.exists(cyc)) m_tout = 1'b1;
      check("ddr_start",  bus.o_ddr_start,     rq);
      check("rd_startp",  bus.o_ddr_rd_startp, rq && !m_req.wxr);
      check("wr_startp",  bus.o_ddr_wr_startp, rq && m_req.wxr);
      check("ddr_wxr",    bus.o_ddr_wxr,       m_req.wxr);
      check("ddr_area",   bus.o_ddr_area,      m_req.area);
      check("ddr_addr",   bus.o_ddr_addr,      m_req.addr);
      check("ddr_size",   bus.o_ddr_size,      m_req.size);
      check("sp_start",   bus.o_sp_start,      e_sp.exists(cyc));
      check("ddr_endp",   bus.o_ddr_endp,      e_dend.exists(cyc));
      check("ctrl_endp",  bus.o_ctrl_endp,     e_cend.exists(cyc));
      check("busy",       bus.o_busy,          e_busy.exists(cyc));
      check("ovr_err",    bus.o_ovr_err,       e_ovr.exists(cyc));
      check("tout_err",   bus.o_tout_err,      m_tout);
      check("frame_time", bus.o_frame_time,    m_ft);
      check("ofs0",       bus.o_ram_offset_addr[31:0],  m_ofs[0]);
      check("ofs1",       bus.o_ram_offset_addr[63:32], m_ofs[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting in the current cycle. Delays are in cycles:
  // read events relative to that channel's request cycle, sp_end relative
  // to the sp_start cycle, write endp relative to the write request cycle.
  task automatic run_frame(input logic [1:0] en, input bit sync, input bit skip,
                           input int de0, input int dl0, input int de1, input int dl1,
                           input int dsp, input int dwr, input bit hold_sp,
                           input int ovr_off, input bit stray);
    int t, q, l, s, p, w, endc, tout;
    int de[2];
    int dl[2];
    de[0] = de0; de[1] = de1; dl[0] = dl0; dl[1] = dl1;
    tout = int'(bus.i_tout_max);
    mon_clear();
    t = cyc;
    g_t = t;
    bus.i_ch_en = en; bus.i_sync_on = sync; bus.i_skip_tx = skip; bus.i_ctrl_startp = 1'b1;

    // Reads: first request the cycle after start; each next request one cycle
    // after the later of that channel's endp/last.
    q = t + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en[c]) begin
        e_req[q] = '{1'b0, 4'(c), (c == 0) ? RD_A0 : RD_A1, RD_SZ};
        d_endp[q + de[c]] = 1'b1;
        d_last[q + dl[c]] = 1'b1;
        l = q + ((de[c] > dl[c]) ? de[c] : dl[c]);
        if (c == 0) g_l0 = l;
        q = l + 1;
      end
    end
    if (stray && en != 2'b00) begin
      d_sp[t + 1]   = 1'b1;      // during the read request: must be ignored
      d_last[t + 1] = 1'b1;
    end
    // q is the sp-request cycle; the sp_start pulse follows one cycle later.
    s = q + 1;
    g_s = s;
    e_sp[s] = 1'b1;
    if (hold_sp && tout != 0) begin
      e_tout[s + tout] = 1'b1;
      endc = s + tout - 1;
    end else begin
      p = s + dsp;
      d_sp[p] = 1'b1;
      e_req[p + 1] = '{1'b1, 4'(NUM_CH), WR_A, WR_SZ};
      w = p + 1 + dwr;
      g_w = w;
      d_endp[w] = 1'b1;
      e_dend[w + 1] = 1'b1;
      if (!sync) e_cend[w + 2] = 1'b1;
      endc = w + 1;
    end
    for (int k = t + 1; k <= endc; k++) e_busy[k] = 1'b1;
    if (ovr_off > 0) begin
      d_start[t + ovr_off] = 1'b1;
      e_ovr[t + ovr_off + 1] = 1'b1;
    end

    for (int k = t + 1; k <= endc + 3; k++) begin
      step();
      if (k == t + 1) begin
        m_tout = 1'b0;
        if (skip || m_ft == FRAME_MAX) begin
          m_ft = 4'd0; m_ofs[0] = '0; m_ofs[1] = '0;
        end else begin
          m_ft = m_ft + 4'd1; m_ofs[0] = m_ofs[0] + OFS0; m_ofs[1] = m_ofs[1] + OFS1;
        end
      end
      bus.i_sync_on        = 1'b0;
      bus.i_skip_tx        = 1'b0;
      bus.i_ctrl_startp    = d_start.exists(cyc);
      bus.i_ddr_endp       = d_endp.exists(cyc);
      bus.i_rxfifo_rd_last = d_last.exists(cyc);
      bus.i_sp_end         = d_sp.exists(cyc);
    end
  endtask

  initial begin
    bus.i_frame_max      = FRAME_MAX;
    bus.i_frame_offset   = {OFS1, OFS0};
    bus.i_rd_addr        = {RD_A1, RD_A0};
    bus.i_rd_size        = RD_SZ;
    bus.i_wr_addr        = WR_A;
    bus.i_wr_size        = WR_SZ;
    bus.i_ch_en          = 2'b11;
    bus.i_tout_max       = '0;
    bus.i_ctrl_startp    = 1'b0;
    bus.i_skip_tx        = 1'b0;
    bus.i_sync_on        = 1'b0;
    bus.i_ddr_endp       = 1'b0;
    bus.i_rxfifo_rd_last = 1'b0;
    bus.i_sp_end         = 1'b0;
    m_ft = '0; m_ofs[0] = '0; m_ofs[1] = '0; m_tout = 1'b0;
    m_req = '{1'b0, 4'd0, '0, '0};
    mon_clear();

    // Reset state
    repeat (3) step();
    check("rst_busy",  bus.o_busy, 0);
    check("rst_ft",    bus.o_frame_time, 0);
    check("rst_start", bus.o_ddr_start, 0);
    check("rst_ofs",   bus.o_ram_offset_addr, 0);
    check("rst_tout",  bus.o_tout_err, 0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (2) step();

    // Frame 1 (T1/T2): both channels
    run_frame(2'b11, 0, 0, 3, 2, 4, 4, 3, 2, 0, 0, 0);
    check("t1_ft_1", bus.o_frame_time, 4'd1);
    check("t1_ofs_1", bus.o_ram_offset_addr[31:0], 32'h100);
    check("t2_rd_first", mon_first_req - g_t, 1);
    check("t2_rd1", mon_rd1_cyc - g_t, 5);
    check("t2_ctrl_endp", mon_cend_cyc - g_w, 2);
    check("t2_n_rd", n_rd, 2);

    // Frame 2 (T3): last 5 cycles before endp, then same cycle
    run_frame(2'b11, 0, 0, 6, 1, 3, 3, 2, 3, 0, 0, 0);
    check("t1_ft_2", bus.o_frame_time, 4'd2);
    check("t1_ofs_2", bus.o_ram_offset_addr[31:0], 32'h200);
    check("t3_rd1", mon_rd1_cyc - g_l0, 1);
    check("t3_sp", mon_sp_cyc - g_t, 13);

    // Frame 3: wrap, with stray events during the read request
    run_frame(2'b11, 0, 0, 2, 2, 2, 1, 1, 1, 0, 0, 1);
    check("t1_ft_3", bus.o_frame_time, 4'd0);
    check("t1_ofs_3", bus.o_ram_offset_addr[31:0], 32'h0);

    // Frame 4
    run_frame(2'b11, 0, 0, 1, 1, 2, 3, 4, 1, 0, 0, 0);
    check("t1_ft_4", bus.o_frame_time, 4'd1);
    check("t1_ofs_4", bus.o_ram_offset_addr[31:0], 32'h100);

    // Frame 5 (T4): no channels enabled
    run_frame(2'b00, 0, 0, 1, 1, 1, 1, 2, 2, 0, 0, 0);
    check("t4_sp", mon_sp_cyc - g_t, 2);
    check("t4_n_rd", n_rd, 0);

    // Frame 6 (T5): sync_on suppresses ctrl_endp
    run_frame(2'b01, 1, 0, 2, 3, 1, 1, 2, 2, 0, 0, 0);
    check("t5_dend", n_dend, 1);
    check("t5_cend", n_cend, 0);

    // Frame 7 (T5): skip_tx forces frame counter to 0
    run_frame(2'b10, 0, 1, 1, 1, 2, 2, 1, 1, 0, 0, 0);
    check("t5_skip_ft", bus.o_frame_time, 4'd0);
    check("t5_skip_ofs1", bus.o_ram_offset_addr[63:32], 32'h0);

    // Frame 8 (T6): watchdog in SP_WAIT, overrun start while busy
    bus.i_tout_max = 24'd100;
    run_frame(2'b01, 0, 0, 2, 2, 1, 1, 0, 0, 1, 10, 0);
    check("t6_tout", mon_tout_cyc - g_s, 100);
    check("t6_ovr", n_ovr, 1);
    check("t6_idle", bus.o_busy, 0);
    check("t6_ft", bus.o_frame_time, 4'd1);
    check("t6_cend", n_cend, 0);

    // Frame 9: watchdog armed but not hit; tout_err cleared at start
    run_frame(2'b11, 0, 0, 3, 3, 2, 4, 5, 3, 0, 0, 0);
    check("t6_clear", bus.o_tout_err, 0);
    check("t6_ft_9", bus.o_frame_time, 4'd2);
    bus.i_tout_max = '0;

    // Reset in the middle of a read wait aborts the frame silently
    chk_en = 1'b0;
    bus.i_ch_en = 2'b11;
    bus.i_ctrl_startp = 1'b1;
    step();
    bus.i_ctrl_startp = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    m_ft = '0; m_ofs[0] = '0; m_ofs[1] = '0; m_tout = 1'b0;
    m_req = '{1'b0, 4'd0, '0, '0};
    mon_clear();
    step();
    chk_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.i_ddr_endp       = (k % 3 == 0);
      bus.i_rxfifo_rd_last = (k % 4 == 1);
      bus.i_sp_end         = (k % 5 == 2);
      step();
    end
    bus.i_ddr_endp = 1'b0; bus.i_rxfifo_rd_last = 1'b0; bus.i_sp_end = 1'b0;
    repeat (2) step();
    check("rst_mid_dend", n_dend, 0);
    check("rst_mid_busy", bus.o_busy, 0);

    // Frame 10: normal operation after the abort
    run_frame(2'b11, 0, 0, 2, 1, 1, 2, 2, 2, 0, 0, 0);
    check("post_rst_ft", bus.o_frame_time, 4'd1);
    check("post_rst_cend", n_cend, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
